// File: rtl/time_keeper.sv
// time_keeper: 24-hour BCD time-of-day counter with a button-driven set/alarm
// mode FSM and a one-cycle alarm pulse.
module time_keeper #(
    parameter logic [7:0] ALM_H_RST = 8'h07,
    parameter logic [7:0] ALM_M_RST = 8'h00
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       alarm_en,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] alm_h_bcd,
    output logic [7:0] alm_m_bcd,
    output logic [2:0] mode,
    output logic       alarm_hit
);
    typedef enum logic [2:0] {
        RUN   = 3'd0,
        SET_H = 3'd1,
        SET_M = 3'd2,
        ALM_H = 3'd3,
        ALM_M = 3'd4
    } mode_t;

    mode_t      state, state_nxt;
    logic       step, inc, hit_pend, hit_nxt;
    logic [7:0] hour_nxt, min_nxt, sec_nxt, alm_h_nxt, alm_m_nxt;

    // Two-digit BCD increment that wraps to 00 after lim.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v == lim) ? 8'h00 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign step = tick_en && (state == RUN || state == ALM_H || state == ALM_M);
    assign inc  = btn_inc && !btn_mode;

    assign sec_nxt   = (state == SET_M && btn_mode) ? 8'h00 :
                       step ? bcd_inc(sec_bcd, 8'h59) : sec_bcd;
    assign min_nxt   = ((step && sec_bcd == 8'h59) || (inc && state == SET_M)) ?
                       bcd_inc(min_bcd, 8'h59) : min_bcd;
    assign hour_nxt  = ((step && min_bcd == 8'h59 && sec_bcd == 8'h59) || (inc && state == SET_H)) ?
                       bcd_inc(hour_bcd, 8'h23) : hour_bcd;
    assign alm_h_nxt = (inc && state == ALM_H) ? bcd_inc(alm_h_bcd, 8'h23) : alm_h_bcd;
    assign alm_m_nxt = (inc && state == ALM_M) ? bcd_inc(alm_m_bcd, 8'h59) : alm_m_bcd;

    // Only a tick-driven advance can arm the alarm; it fires one cycle later.
    assign hit_nxt = step && alarm_en && sec_nxt == 8'h00 &&
                     hour_nxt == alm_h_nxt && min_nxt == alm_m_nxt;

    always_comb begin
        case (state)
            RUN:     state_nxt = btn_mode ? SET_H : RUN;
            SET_H:   state_nxt = btn_mode ? SET_M : SET_H;
            SET_M:   state_nxt = btn_mode ? ALM_H : SET_M;
            ALM_H:   state_nxt = btn_mode ? ALM_M : ALM_H;
            ALM_M:   state_nxt = btn_mode ? RUN   : ALM_M;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            hour_bcd  <= 8'h00;
            min_bcd   <= 8'h00;
            sec_bcd   <= 8'h00;
            alm_h_bcd <= ALM_H_RST;
            alm_m_bcd <= ALM_M_RST;
            hit_pend  <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            state     <= state_nxt;
            hour_bcd  <= hour_nxt;
            min_bcd   <= min_nxt;
            sec_bcd   <= sec_nxt;
            alm_h_bcd <= alm_h_nxt;
            alm_m_bcd <= alm_m_nxt;
            hit_pend  <= hit_nxt;
            alarm_hit <= hit_pend;
        end
    end

    assign mode = state;
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed-vector bench for time_keeper with hand-computed expectations.
module tb_time_keeper;
    logic       clk_in = 1'b0, rst = 1'b1;
    logic       tick_en = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, alarm_en = 1'b0;
    logic [7:0] hour_bcd, min_bcd, sec_bcd, alm_h_bcd, alm_m_bcd;
    logic [2:0] mode;
    logic       alarm_hit;
    int         total = 0, passed = 0, hits = 0;

    time_keeper dut (
        .clk_in(clk_in), .rst(rst), .tick_en(tick_en), .btn_mode(btn_mode),
        .btn_inc(btn_inc), .alarm_en(alarm_en), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
        .sec_bcd(sec_bcd), .alm_h_bcd(alm_h_bcd), .alm_m_bcd(alm_m_bcd), .mode(mode),
        .alarm_hit(alarm_hit)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) if (alarm_hit) hits <= hits + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic m, input logic i, input logic t);
        @(negedge clk_in);
        btn_mode = m; btn_inc = i; tick_en = t;
        @(negedge clk_in);
        btn_mode = 0; btn_inc = 0; tick_en = 0;
    endtask

    task automatic press(input int n);
        repeat (n) drive(1, 0, 0);
    endtask

    task automatic incs(input int n);
        repeat (n) drive(0, 1, 0);
    endtask

    task automatic ticks(input int n);
        @(negedge clk_in);
        tick_en = 1;
        repeat (n) @(negedge clk_in);
        tick_en = 0;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".h"}, hour_bcd, h);
        check({tag, ".m"}, min_bcd, m);
        check({tag, ".s"}, sec_bcd, s);
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        rst = 0;
        check_time("reset", 'h00, 'h00, 'h00);
        check("reset.alm_h", alm_h_bcd, 'h07);
        check("reset.alm_m", alm_m_bcd, 'h00);
        check("reset.mode", mode, 0);
        check("reset.hit", alarm_hit, 0);
        ticks(10);
        check("ten_ticks", sec_bcd, 'h10);

        press(1);
        check("mode_set_h", mode, 1);
        incs(23);
        check("set_hour_23", hour_bcd, 'h23);
        press(1);
        check("mode_set_m", mode, 2);
        incs(59);
        check("set_min_59", min_bcd, 'h59);
        check("set_frozen_sec", sec_bcd, 'h10);
        press(1);
        check("exit_set_m_sec", sec_bcd, 'h00);
        press(2);
        check("mode_run", mode, 0);
        ticks(59);
        check_time("pre_midnight", 'h23, 'h59, 'h59);
        ticks(1);
        check_time("midnight", 'h00, 'h00, 'h00);

        press(2);
        incs(9);
        press(1);
        ticks(59);
        check_time("carry_pre", 'h00, 'h09, 'h59);
        ticks(1);
        check_time("carry_min", 'h00, 'h10, 'h00);
        press(3);
        incs(10);
        check("hour_09_10", hour_bcd, 'h10);
        incs(10);
        check("hour_19_20", hour_bcd, 'h20);
        repeat (50) drive(0, 0, 1);
        check_time("set_h_frozen", 'h20, 'h10, 'h00);

        press(4);
        check("back_to_run", mode, 0);
        ticks(37);
        check("sec_37", sec_bcd, 'h37);
        press(2);
        drive(1, 0, 1);
        check("exit_tick_mode", mode, 3);
        check_time("exit_tick", 'h20, 'h10, 'h00);
        press(2);
        drive(0, 1, 0);
        check_time("inc_in_run", 'h20, 'h10, 'h00);
        check("inc_in_run.alm_h", alm_h_bcd, 'h07);

        press(1);
        incs(4);
        press(1);
        incs(50);
        press(1);
        incs(17);
        press(1);
        incs(1);
        press(1);
        check("alm_h_set", alm_h_bcd, 'h00);
        check("alm_m_set", alm_m_bcd, 'h01);
        check_time("alarm_start", 'h00, 'h00, 'h00);
        alarm_en = 1;
        ticks(59);
        check("pre_alarm_hit", alarm_hit, 0);
        tick_en = 1;
        @(negedge clk_in);
        tick_en = 0;
        check("alarm_min", min_bcd, 'h01);
        check("alarm_hit_n", alarm_hit, 0);
        @(negedge clk_in);
        check("alarm_hit_n1", alarm_hit, 1);
        @(negedge clk_in);
        check("alarm_hit_n2", alarm_hit, 0);
        repeat (3) @(negedge clk_in);
        check("alarm_count", hits, 1);

        alarm_en = 0;
        press(4);
        incs(1);
        press(1);
        check("alm_m_02", alm_m_bcd, 'h02);
        ticks(60);
        check_time("no_alarm_time", 'h00, 'h02, 'h00);
        repeat (3) @(negedge clk_in);
        check("no_alarm_count", hits, 1);

        press(1);
        drive(1, 1, 0);
        check("mode_inc_mode", mode, 2);
        check("mode_inc_hour", hour_bcd, 'h00);
        press(2);
        drive(0, 1, 1);
        check("alm_m_tick_sec", sec_bcd, 'h01);
        check("alm_m_tick_alm", alm_m_bcd, 'h03);
        press(1);

        press(1);
        incs(12);
        press(1);
        incs(32);
        press(3);
        ticks(56);
        check_time("pre_reset", 'h12, 'h34, 'h56);
        #2 rst = 1;
        #1;
        check_time("async_reset", 'h00, 'h00, 'h00);
        check("async_reset.alm_m", alm_m_bcd, 'h00);
        check("async_reset.alm_h", alm_h_bcd, 'h07);
        @(negedge clk_in);
        rst = 0;
        ticks(1);
        check("post_reset_tick", sec_bcd, 'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
